// File: rtl/alu_share_arbiter_if.sv
// Request/result bundle for alu_share_arbiter.
// master: the requesters and result consumer side. slave: the arbiter.
interface alu_share_arbiter_if;
   // requester 0 (fetch/branch path)
   logic        req0_valid;
   logic        req0_ready;
   logic [2:0]  req0_op;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        req0_lock;
   // requester 1 (execute path)
   logic        req1_valid;
   logic        req1_ready;
   logic [2:0]  req1_op;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic        req1_lock;
   // tagged result bus
   logic        res_valid;
   logic        res_id;
   logic [31:0] res_result;
   logic        res_zero;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b, req0_lock,
      output req1_valid, req1_op, req1_a, req1_b, req1_lock,
      input  req0_ready, req1_ready,
      input  res_valid, res_id, res_result, res_zero
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, req0_lock,
      input  req1_valid, req1_op, req1_a, req1_b, req1_lock,
      output req0_ready, req1_ready,
      output res_valid, res_id, res_result, res_zero
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one 32-bit ALU shared by two requesters.
// Round-robin grant, issue register (stage 1), result register (stage 2),
// single tagged result bus, 1 op/cycle.
// Optional feature macro: ALU_ARB_LOCK_EN (burst lock with MAX_BURST limit).
module alu_share_arbiter #(
   parameter logic PRIO_RESET = 1'b0,
   parameter int   MAX_BURST  = 4
) (
   input logic               clk,
   input logic               reset,
   alu_share_arbiter_if.slave bus
);

   localparam int STAGES = 2;

   // vld_pipe[1] = issue register valid, vld_pipe[2] = result valid
   logic [STAGES:1] vld_pipe;

   logic        last_id;
   logic        gnt0;
   logic        gnt1;
   logic        xfer;
   logic        gnt_id;
   logic        tie_id;

   logic [2:0]  s1_op;
   logic [31:0] s1_a;
   logic [31:0] s1_b;
   logic        s1_id;

   logic [31:0] alu_y;

   logic        res_id;
   logic [31:0] res_result;
   logic        res_zero;

`ifdef ALU_ARB_LOCK_EN
   localparam logic [3:0] MAX_B = 4'(MAX_BURST);

   // consecutive locked transfers by last_id; 0 means no burst in progress
   logic [3:0] burst_cnt;
   logic       gnt_lock;
   logic       hold_last;

   // the last granted requester keeps a tie while its burst is live and under the limit
   always_comb begin
      hold_last = 1'b0;
      if ((last_id ? bus.req1_lock : bus.req0_lock) &&
          (burst_cnt != 4'd0) && (burst_cnt < MAX_B))
         hold_last = 1'b1;
      tie_id   = hold_last ? last_id : ~last_id;
      gnt_lock = gnt_id ? bus.req1_lock : bus.req0_lock;
   end

   // burst counter: grows on repeated locked transfers, clears on switch/unlock/idle
   always_ff @(posedge clk) begin
      if (reset) begin
         burst_cnt <= 4'd0;
      end else if (!xfer || !gnt_lock) begin
         burst_cnt <= 4'd0;
      end else if (gnt_id != last_id) begin
         burst_cnt <= 4'd1;
      end else if (burst_cnt < MAX_B) begin
         burst_cnt <= burst_cnt + 4'd1;
      end
   end
`else
   // lock inputs exist on the bus but play no part in plain round-robin
   logic lock_unused;
   assign lock_unused = bus.req0_lock ^ bus.req1_lock;

   // plain round-robin: the requester that did not go last wins a tie
   always_comb begin
      tie_id = ~last_id;
   end
`endif

   // grant: sole valid wins, ties resolved by tie_id, nothing granted in reset
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (bus.req0_valid && bus.req1_valid) begin
            gnt0 = ~tie_id;
            gnt1 = tie_id;
         end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
         end
      end
      xfer   = gnt0 | gnt1;
      gnt_id = gnt1;
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;

   // stage 1: capture the granted op and remember who went last
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe[1] <= 1'b0;
         last_id     <= ~PRIO_RESET;
         s1_op       <= 3'd0;
         s1_a        <= 32'd0;
         s1_b        <= 32'd0;
         s1_id       <= 1'b0;
      end else begin
         vld_pipe[1] <= xfer;
         if (xfer) begin
            last_id <= gnt_id;
            s1_id   <= gnt_id;
            s1_op   <= gnt_id ? bus.req1_op : bus.req0_op;
            s1_a    <= gnt_id ? bus.req1_a  : bus.req0_a;
            s1_b    <= gnt_id ? bus.req1_b  : bus.req0_b;
         end
      end
   end

   // shared ALU on stage-1 contents; all arithmetic wraps mod 2^32
   always_comb begin
      alu_y = 32'd0;
      case (s1_op)
         3'd0: alu_y = s1_a & s1_b;
         3'd1: alu_y = s1_a | s1_b;
         3'd2: alu_y = s1_a[31] ? (~s1_a + 32'd1) : s1_a;   // 0x8000_0000 maps to itself
         3'd3: alu_y = s1_a + s1_b;
         3'd4: alu_y = s1_a - s1_b;
         3'd5: alu_y = s1_a + 32'd1;
         3'd6: alu_y = {31'd0, ($signed(s1_a) < $signed(s1_b))};
         3'd7: alu_y = s1_a;
         default: alu_y = 32'd0;
      endcase
   end

   // stage 2: result register; payload holds while no result is produced
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe[2] <= 1'b0;
         res_id      <= 1'b0;
         res_result  <= 32'd0;
         res_zero    <= 1'b1;
      end else begin
         vld_pipe[2] <= vld_pipe[1];
         if (vld_pipe[1]) begin
            res_id     <= s1_id;
            res_result <= alu_y;
            res_zero   <= (alu_y == 32'd0);
         end
      end
   end

   assign bus.res_valid  = vld_pipe[2];
   assign bus.res_id     = res_id;
   assign bus.res_result = res_result;
   assign bus.res_zero   = res_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a result scoreboard.
// Expected grants are written per step; expected results come from a local ALU model.
module tb_alu_share_arbiter;

   logic clk;
   logic reset;

   alu_share_arbiter_if bus ();

   alu_share_arbiter #(.PRIO_RESET(1'b0), .MAX_BURST(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic        id;
      logic [31:0] result;
   } exp_t;

   exp_t        q[$];
   int          cyc;
   int          n_asserts;
   int          n_fail;
   logic        h_id;
   logic [31:0] h_res;

   function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] y;
      case (op)
         3'd0: y = a & b;
         3'd1: y = a | b;
         3'd2: y = (a[31] == 1'b1) ? (32'd0 - a) : a;
         3'd3: y = a + b;
         3'd4: y = a - b;
         3'd5: y = a + 32'd1;
         3'd6: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: y = a;
      endcase
      return y;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set0(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic lk);
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_lock = lk;
   endtask

   task automatic set1(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic lk);
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_lock = lk;
   endtask

   // one cycle: eg = expected grant (0, 1, or 2 for none)
   task automatic tick(input int eg, input string tag);
      exp_t e;
      @(negedge clk);
      chk({tag, " ready0"}, 32'(bus.req0_ready), 32'(eg == 0));
      chk({tag, " ready1"}, 32'(bus.req1_ready), 32'(eg == 1));
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk({tag, " res_valid"},  32'(bus.res_valid), 32'd1);
         chk({tag, " res_id"},     32'(bus.res_id), 32'(e.id));
         chk({tag, " res_result"}, bus.res_result, e.result);
         chk({tag, " res_zero"},   32'(bus.res_zero), 32'(e.result == 32'd0));
         h_id  = e.id;
         h_res = e.result;
      end else begin
         chk({tag, " idle res_valid"},  32'(bus.res_valid), 32'd0);
         chk({tag, " hold res_id"},     32'(bus.res_id), 32'(h_id));
         chk({tag, " hold res_result"}, bus.res_result, h_res);
         chk({tag, " hold res_zero"},   32'(bus.res_zero), 32'(h_res == 32'd0));
      end
      if (eg == 0)
         q.push_back('{cyc + 2, 1'b0, alu_model(bus.req0_op, bus.req0_a, bus.req0_b)});
      else if (eg == 1)
         q.push_back('{cyc + 2, 1'b1, alu_model(bus.req1_op, bus.req1_a, bus.req1_b)});
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // reset for 1 + nextra cycles; anything in flight is dropped
   task automatic do_reset(input int nextra);
      reset = 1'b1;
      tick(2, "rst0");
      q.delete();
      h_id  = 1'b0;
      h_res = 32'd0;
      for (int i = 0; i < nextra; i++) tick(2, "rst");
      reset = 1'b0;
   endtask

   logic [2:0]  t_op [11];
   logic [31:0] t_a  [11];
   logic [31:0] t_b  [11];

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      cyc       = 0;
      h_id      = 1'b0;
      h_res     = 32'd0;
      reset     = 1'b1;
      set0(1'b1, 3'd3, 32'd5, 32'd7, 1'b0);   // valid held through reset
      set1(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      @(posedge clk);
      #1;

      // reset state, valid high must not see ready
      do_reset(2);
      chk("reset res_zero",   32'(bus.res_zero), 32'd1);
      chk("reset res_result", bus.res_result, 32'd0);

      // req0 alone: 5+7
      tick(0, "add");
      set0(1'b0, 3'd3, 32'd5, 32'd7, 1'b0);
      tick(2, "add_wait");
      tick(2, "add_res");
      chk("add explicit 12", bus.res_result, 32'd12);

      // both valid every cycle from reset: 0,1,0,1,...
      do_reset(1);
      set0(1'b1, 3'd0, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
      set1(1'b1, 3'd1, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
      for (int i = 0; i < 6; i++) tick(i % 2, "rr");
      set0(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      set1(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      tick(2, "rr_drain");
      tick(2, "rr_drain");

      // op table, ports alternate, single requester per cycle
      t_op[0]  = 3'd4; t_a[0]  = 32'd3;          t_b[0]  = 32'd3;
      t_op[1]  = 3'd6; t_a[1]  = 32'hFFFF_FFFF;  t_b[1]  = 32'd0;
      t_op[2]  = 3'd2; t_a[2]  = 32'h8000_0000;  t_b[2]  = 32'd0;
      t_op[3]  = 3'd5; t_a[3]  = 32'hFFFF_FFFF;  t_b[3]  = 32'd9;
      t_op[4]  = 3'd0; t_a[4]  = 32'hDEAD_BEEF;  t_b[4]  = 32'h0F0F_0F0F;
      t_op[5]  = 3'd1; t_a[5]  = 32'h1200_0034;  t_b[5]  = 32'h0056_7800;
      t_op[6]  = 3'd3; t_a[6]  = 32'h7FFF_FFFF;  t_b[6]  = 32'd1;
      t_op[7]  = 3'd7; t_a[7]  = 32'hCAFE_F00D;  t_b[7]  = 32'd1;
      t_op[8]  = 3'd6; t_a[8]  = 32'd5;          t_b[8]  = 32'hFFFF_FFFE;
      t_op[9]  = 3'd2; t_a[9]  = 32'hFFFF_FFFB;  t_b[9]  = 32'd0;
      t_op[10] = 3'd4; t_a[10] = 32'd0;          t_b[10] = 32'd1;
      for (int i = 0; i < 11; i++) begin
         if (i % 2 == 0) begin
            set0(1'b1, t_op[i], t_a[i], t_b[i], 1'b0);
            set1(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
         end else begin
            set0(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
            set1(1'b1, t_op[i], t_a[i], t_b[i], 1'b0);
         end
         tick(i % 2, "op");
      end
      set0(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      set1(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      tick(2, "op_drain");
      tick(2, "op_drain");

      // reset the cycle after a transfer drops it; tie afterwards goes to requester 0
      set1(1'b1, 3'd3, 32'd1, 32'd1, 1'b0);
      tick(1, "pre_rst");
      set1(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      do_reset(0);
      tick(2, "post_rst");
      chk("post_rst res_zero", 32'(bus.res_zero), 32'd1);
      set0(1'b1, 3'd7, 32'h0000_0A0A, 32'd0, 1'b0);
      set1(1'b1, 3'd5, 32'h0000_0010, 32'd0, 1'b0);
      tick(0, "tie0");
      tick(1, "tie1");
      set0(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      set1(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      tick(2, "tie_drain");
      tick(2, "tie_drain");

      // req0 requests a lock while req1 waits continuously
      do_reset(1);
      set0(1'b1, 3'd3, 32'd100, 32'd1, 1'b1);
      set1(1'b1, 3'd4, 32'd100, 32'd1, 1'b0);
`ifdef ALU_ARB_LOCK_EN
      tick(0, "lock");
      tick(0, "lock");
      tick(0, "lock");
      tick(0, "lock");
      tick(1, "lock_peer");
      tick(0, "lock_after");
`else
      for (int i = 0; i < 6; i++) tick(i % 2, "nolock");
`endif
      set0(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      set1(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      tick(2, "lock_drain");
      tick(2, "lock_drain");
      tick(2, "final_idle");
      chk("scoreboard empty", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
